// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, imem req/ready handshake, one-entry skid buffer, redirect flush.
// Optional performance counters enabled by defining IFETCH_PERF_CNT_EN.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic [31:0] inst_out,
   output logic [31:0] pc_out,
`ifdef IFETCH_PERF_CNT_EN
   output logic        inst_valid,
   output logic [31:0] fetch_count,
   output logic [31:0] flush_count
`else
   output logic        inst_valid
`endif
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;
   localparam logic [1:0] DRAIN = 2'd3;

   logic [1:0]  state;
   logic [31:0] pc_reg;
   logic [31:0] drain_addr;
   logic [31:0] skid_inst;
   logic [31:0] skid_pc;
   logic        out_taken;

   // DRAIN keeps presenting the abandoned address until memory completes it.
   assign imem_req  = (state == FETCH) || (state == DRAIN);
   assign imem_addr = (state == DRAIN) ? drain_addr : pc_reg;
   assign out_taken = inst_valid && !stall;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         pc_reg     <= RESET_PC;
         drain_addr <= RESET_PC;
         skid_inst  <= '0;
         skid_pc    <= '0;
         inst_out   <= NOP_INST;
         pc_out     <= RESET_PC;
         inst_valid <= 1'b0;
      end else if (redirect_valid) begin
         pc_reg     <= redirect_pc & 32'hFFFF_FFFC;
         inst_valid <= 1'b0;
         inst_out   <= NOP_INST;
         case (state)
            FETCH: begin
               if (!imem_ready) begin
                  state      <= DRAIN;
                  drain_addr <= pc_reg;
               end
            end
            DRAIN: begin
               if (imem_ready) state <= FETCH;
            end
            default: state <= FETCH;
         endcase
      end else begin
         case (state)
            IDLE: state <= FETCH;
            FETCH: begin
               if (imem_ready) begin
                  pc_reg <= pc_reg + 32'd4;
                  if (!inst_valid || !stall) begin
                     inst_out   <= imem_rdata;
                     pc_out     <= pc_reg;
                     inst_valid <= 1'b1;
                  end else begin
                     skid_inst <= imem_rdata;
                     skid_pc   <= pc_reg;
                     state     <= FULL;
                  end
               end else if (out_taken) begin
                  inst_valid <= 1'b0;
                  inst_out   <= NOP_INST;
               end
            end
            FULL: begin
               if (!stall) begin
                  inst_out   <= skid_inst;
                  pc_out     <= skid_pc;
                  inst_valid <= 1'b1;
                  state      <= FETCH;
               end
            end
            default: begin
               if (imem_ready) state <= FETCH;
            end
         endcase
      end
   end

`ifdef IFETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_count <= '0;
         flush_count <= '0;
      end else begin
         if (redirect_valid) flush_count <= flush_count + 32'd1;
         if ((state == FETCH) && imem_ready && !redirect_valid)
            fetch_count <= fetch_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch against a queue-based transaction model.
module tb_instruction_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        stall;
   logic [31:0] inst_out;
   logic [31:0] pc_out;
   logic        inst_valid;

   int vectors;
   int miscompares;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   // Model: instructions delivered but not yet consumed, next fetch PC, pending discard.
   ent_t        q[$];
   logic [31:0] m_pc;
   logic [31:0] m_daddr;
   logic        m_drain;
   logic        m_started;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a | 32'h0010_0000;
   endfunction

   assign imem_rdata = mem(imem_addr);

   instruction_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
      .inst_out(inst_out), .pc_out(pc_out), .inst_valid(inst_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_pc      = RESET_PC;
      m_daddr   = RESET_PC;
      m_drain   = 1'b0;
      m_started = 1'b0;
   endtask

   task automatic compare();
      logic exp_req;
      exp_req = m_started && (m_drain || q.size() < 2);
      chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
      chk("imem_addr", imem_addr, m_drain ? m_daddr : m_pc);
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, q.size() > 0});
      if (q.size() > 0) begin
         chk("pc_out", pc_out, q[0].pc);
         chk("inst_out", inst_out, q[0].inst);
      end else begin
         chk("inst_out_nop", inst_out, NOP_INST);
      end
   endtask

   task automatic model_update(input logic r, input logic st, input logic rdy,
                               input logic rv, input logic [31:0] rp);
      logic        req;
      logic        acc;
      logic [31:0] addr;
      ent_t        e;
      if (!r) begin
         model_reset();
         return;
      end
      req  = m_started && (m_drain || q.size() < 2);
      addr = m_drain ? m_daddr : m_pc;
      acc  = req && rdy;
      if (rv) begin
         if (m_drain) begin
            if (acc) m_drain = 1'b0;
         end else if (req && !rdy) begin
            m_drain = 1'b1;
            m_daddr = m_pc;
         end
         q.delete();
         m_pc = rp & 32'hFFFF_FFFC;
      end else if (m_drain) begin
         if (acc) m_drain = 1'b0;
      end else begin
         if (q.size() > 0 && !st) void'(q.pop_front());
         if (acc) begin
            e.pc   = addr;
            e.inst = mem(addr);
            q.push_back(e);
            m_pc = m_pc + 32'd4;
         end
      end
      m_started = 1'b1;
   endtask

   // Entered and left at a falling edge; compares, drives, then advances one clock.
   task automatic cycle(input logic r, input logic st, input logic rdy,
                        input logic rv, input logic [31:0] rp);
      compare();
      rst_n          = r;
      stall          = st;
      imem_ready     = rdy;
      redirect_valid = rv;
      redirect_pc    = rp;
      model_update(r, st, rdy, rv, rp);
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      vectors        = 0;
      miscompares    = 0;
      rst_n          = 1'b0;
      stall          = 1'b0;
      imem_ready     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);

      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", {31'b0, inst_valid}, 32'd0);
      chk("rst_inst", inst_out, 32'h0000_0013);
      chk("rst_pc", pc_out, 32'h0);

      // Streaming after reset release
      cycle(1, 0, 1, 0, 0);
      cycle(1, 0, 1, 0, 0);
      chk("first_pc", pc_out, 32'h0);
      chk("first_inst", inst_out, 32'h0010_0000);
      cycle(1, 0, 1, 0, 0);
      chk("second_pc", pc_out, 32'h4);
      chk("second_addr", imem_addr, 32'h8);

      // Memory wait states at 0x8
      for (int i = 0; i < 3; i++) begin
         cycle(1, 0, 0, 0, 0);
         chk("wait_req", {31'b0, imem_req}, 32'd1);
         chk("wait_addr", imem_addr, 32'h8);
      end
      chk("wait_valid", {31'b0, inst_valid}, 32'd0);
      cycle(1, 0, 1, 0, 0);
      chk("wait_pc", pc_out, 32'h8);

      // Skid buffer under stall
      cycle(1, 0, 1, 1, 32'h10);
      cycle(1, 0, 1, 0, 0);
      chk("skid_pc0", pc_out, 32'h10);
      for (int i = 0; i < 4; i++) cycle(1, 1, 1, 0, 0);
      chk("skid_req", {31'b0, imem_req}, 32'd0);
      chk("skid_hold", pc_out, 32'h10);
      cycle(1, 0, 1, 0, 0);
      chk("skid_out", pc_out, 32'h14);
      chk("skid_next", imem_addr, 32'h18);

      // Redirect with full skid and stall
      cycle(1, 1, 1, 0, 0);
      cycle(1, 1, 1, 1, 32'h300);
      chk("fullredir_valid", {31'b0, inst_valid}, 32'd0);
      chk("fullredir_addr", imem_addr, 32'h300);

      // Redirect while request outstanding -> drain
      cycle(1, 0, 1, 1, 32'h20);
      cycle(1, 0, 0, 1, 32'h203);
      chk("drain_addr", imem_addr, 32'h20);
      chk("drain_req", {31'b0, imem_req}, 32'd1);
      cycle(1, 0, 0, 0, 0);
      chk("drain_hold", imem_addr, 32'h20);
      cycle(1, 0, 1, 0, 0);
      chk("drain_next", imem_addr, 32'h200);
      chk("drain_valid", {31'b0, inst_valid}, 32'd0);
      cycle(1, 0, 1, 0, 0);
      chk("drain_pc", pc_out, 32'h200);
      chk("drain_inst", inst_out, 32'h0010_0200);

      // PC wraparound
      cycle(1, 0, 1, 1, 32'hFFFF_FFFC);
      cycle(1, 0, 1, 0, 0);
      chk("wrap_pc0", pc_out, 32'hFFFF_FFFC);
      cycle(1, 0, 1, 0, 0);
      chk("wrap_pc1", pc_out, 32'h0);
      chk("wrap_inst1", inst_out, 32'h0010_0000);

      // Randomized traffic including occasional mid-transaction reset
      for (int n = 0; n < 4000; n++) begin
         logic        r;
         logic        st;
         logic        rdy;
         logic        rv;
         logic [31:0] rp;
         r   = ($urandom_range(0, 199) != 0);
         st  = ($urandom_range(0, 99) < 35);
         rdy = ($urandom_range(0, 99) < 70);
         rv  = ($urandom_range(0, 99) < 6);
         rp  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                           : $urandom;
         cycle(r, st, rdy, rv, rp);
      end
      compare();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
